store_rmw_ctrl: RTL and testbench

STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

---
 rtl/store_rmw_ctrl_if.sv | 31 +++
 rtl/store_rmw_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_store_rmw_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_rmw_ctrl_if.sv
// store_rmw_ctrl_if -- request/RAM bus bundle for store_rmw_ctrl.
//   Request side : req_valid, req_ready, req_addr, req_mask, req_wdata
//   RAM side     : ram_addr, ram_re, ram_rdata, ram_rvalid, ram_we, ram_wdata
//   Status       : done, err
// Modport slave is the controller's view, modport master is the
// requester/RAM environment's view.
interface store_rmw_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_mask;
  logic [31:0] req_wdata;
  logic [31:0] ram_addr;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic        ram_rvalid;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic        done;
  logic        err;

  modport slave (
    input  req_valid, req_addr, req_mask, req_wdata, ram_rdata, ram_rvalid,
    output req_ready, ram_addr, ram_re, ram_we, ram_wdata, done, err
  );

  modport master (
    output req_valid, req_addr, req_mask, req_wdata, ram_rdata, ram_rvalid,
    input  req_ready, ram_addr, ram_re, ram_we, ram_wdata, done, err
  );
endinterface

// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl -- store controller performing read-modify-write for
// byte/half stores into a word-wide RAM.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : store_rmw_ctrl_if.slave (request handshake, RAM port, done/err)
// Parameter WAIT_MAX: WAIT cycles allowed for ram_rvalid before timeout.
// Optional feature macro STORE_MISALIGN_CHECK_EN: misaligned half/word
// stores complete immediately with err and no RAM access. Without it the
// misaligned low address bits are simply ignored.
// All outputs are registers loaded from the next-state decode, so they
// line up with the state they belong to.
module store_rmw_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  store_rmw_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state_r, state_nx_s;
  logic [31:0]    addr_r, wdata_r;
  logic [1:0]     mask_r;
  logic [CW-1:0]  cnt_r, cnt_nx_s;
  logic           accept_s, misalign_s, err_nx_s;
  logic [31:0]    wdata_nx_s, addr_nx_s;

  logic           req_ready_r, ram_re_r, ram_we_r, done_r, err_r;
  logic [31:0]    ram_addr_r, ram_wdata_r;

  // Merge store data into the read word according to width and lane.
  function automatic logic [31:0] merge_word(input logic [1:0]  mask,
                                             input logic [1:0]  lane,
                                             input logic [31:0] wd,
                                             input logic [31:0] rd);
    logic [31:0] m;
    m = rd;
    if (mask[1]) begin
      m = wd;
    end else if (mask[0]) begin
      if (lane[1]) m = {wd[15:0], rd[15:0]};
      else         m = {rd[31:16], wd[15:0]};
    end else begin
      case (lane)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        2'd3:    m[31:24] = wd[7:0];
        default: m = rd;
      endcase
    end
    return m;
  endfunction

  assign accept_s = bus.req_valid && (state_r == IDLE);

  // Misaligned-request detection (only active with the optional check).
  always_comb begin
`ifdef STORE_MISALIGN_CHECK_EN
    if (bus.req_mask[1])      misalign_s = (bus.req_addr[1:0] != 2'b00);
    else if (bus.req_mask[0]) misalign_s = bus.req_addr[0];
    else                      misalign_s = 1'b0;
`else
    misalign_s = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state, wait counter and next output values.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    err_nx_s   = 1'b0;
    wdata_nx_s = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (misalign_s) begin
            state_nx_s = DONE;
            err_nx_s   = 1'b1;
          end else if (bus.req_mask[1]) begin
            state_nx_s = WRITE;
            wdata_nx_s = bus.req_wdata;
          end else begin
            state_nx_s = READ;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      READ: begin
        state_nx_s = WAIT;
        cnt_nx_s   = CW'(1'b1);
      end
      WAIT: begin
        if (bus.ram_rvalid) begin
          state_nx_s = WRITE;
          cnt_nx_s   = '0;
          // Merge straight from the bus so the write word is ready in WRITE.
          wdata_nx_s = merge_word(mask_r, addr_r[1:0], wdata_r, bus.ram_rdata);
        end else if (cnt_r >= WAIT_LIM) begin
          state_nx_s = DONE;
          cnt_nx_s   = '0;
          err_nx_s   = 1'b1;
        end else begin
          cnt_nx_s   = cnt_r + CW'(1'b1);
        end
      end
      WRITE:   state_nx_s = DONE;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // The accepting cycle addresses from the bus, later cycles from the latch.
  assign addr_nx_s = accept_s ? bus.req_addr : addr_r;

  // Request latch and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      mask_r  <= 2'b00;
      cnt_r   <= '0;
    end else begin
      cnt_r <= cnt_nx_s;
      if (accept_s) begin
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
        mask_r  <= bus.req_mask;
      end
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b1;
      ram_re_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      ram_addr_r  <= 32'h0000_0000;
      ram_wdata_r <= 32'h0000_0000;
    end else begin
      req_ready_r <= (state_nx_s == IDLE);
      ram_re_r    <= (state_nx_s == READ);
      ram_we_r    <= (state_nx_s == WRITE);
      done_r      <= (state_nx_s == DONE);
      err_r       <= err_nx_s;
      ram_wdata_r <= wdata_nx_s;
      if ((state_nx_s == READ) || (state_nx_s == WAIT) || (state_nx_s == WRITE))
        ram_addr_r <= {addr_nx_s[31:2], 2'b00};
      else
        ram_addr_r <= 32'h0000_0000;
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.ram_re    = ram_re_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// tb_store_rmw_ctrl -- scoreboard bench for store_rmw_ctrl.
// Stimulus pushes hand-computed expected RAM reads, writes and completions
// (with the cycle they must appear in) into queues; a negedge monitor pops
// and compares whenever the DUT strobes ram_re, ram_we or done.
module tb_store_rmw_ctrl;
  localparam int WAIT_MAX = 15;

  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [31:0] addr; int cyc; } re_t;
  typedef struct { logic err; int cyc; } dn_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  wr_t wr_q[$];
  re_t re_q[$];
  dn_t dn_q[$];

  int          rsp_delay = -1;
  logic [31:0] rsp_data  = 32'h0;

  store_rmw_ctrl_if bus();

  store_rmw_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every DUT strobe against the scoreboard.
  always @(negedge clk) begin
    wr_t w;
    re_t r;
    dn_t d;
    if (rst_n) begin
      if (bus.ram_re) begin
        if (re_q.size() == 0) flag("unexpected_ram_re");
        else begin
          r = re_q.pop_front();
          chk("re_addr", bus.ram_addr, r.addr);
          chk("re_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
      if (bus.ram_we) begin
        if (wr_q.size() == 0) flag("unexpected_ram_we");
        else begin
          w = wr_q.pop_front();
          chk("we_addr", bus.ram_addr, w.addr);
          chk("we_data", bus.ram_wdata, w.data);
          chk("we_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
      if (bus.done) begin
        if (dn_q.size() == 0) flag("unexpected_done");
        else begin
          d = dn_q.pop_front();
          chk("done_err", {31'd0, bus.err}, {31'd0, d.err});
          chk("done_cycle", 32'(cyc), 32'(d.cyc));
        end
      end
      if (bus.err && !bus.done) flag("err_without_done");
    end
  end

  // RAM responder: answer a read strobe after rsp_delay negedges (<0: never).
  initial begin
    int d;
    logic [31:0] v;
    bus.ram_rvalid = 1'b0;
    bus.ram_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.ram_re && (rsp_delay >= 0)) begin
        d = rsp_delay;
        v = rsp_data;
        repeat (d) @(negedge clk);
        bus.ram_rvalid = 1'b1;
        bus.ram_rdata  = v;
        @(negedge clk);
        bus.ram_rvalid = 1'b0;
        bus.ram_rdata  = 32'h0;
      end
    end
  end

  // kind: 0 normal store, 1 read timeout, 2 misalign error, 3 abandoned (reset)
  task automatic issue(input logic [31:0] a, input logic [1:0] m, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly, input int kind,
                       input logic [31:0] ea, input logic [31:0] ed, output int acc);
    int n;
    @(negedge clk);
    bus.req_addr  = a;
    bus.req_mask  = m;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    rsp_data      = rd;
    rsp_delay     = dly;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      flag("accept_timeout");
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    case (kind)
      0: begin
        if (m[1]) begin
          wr_q.push_back('{addr: ea, data: ed, cyc: acc + 1});
          dn_q.push_back('{err: 1'b0, cyc: acc + 2});
        end else begin
          re_q.push_back('{addr: ea, cyc: acc + 1});
          wr_q.push_back('{addr: ea, data: ed, cyc: acc + 2 + dly});
          dn_q.push_back('{err: 1'b0, cyc: acc + 3 + dly});
        end
      end
      1: begin
        re_q.push_back('{addr: ea, cyc: acc + 1});
        dn_q.push_back('{err: 1'b1, cyc: acc + 2 + WAIT_MAX});
      end
      2: dn_q.push_back('{err: 1'b1, cyc: acc + 1});
      default: re_q.push_back('{addr: ea, cyc: acc + 1});
    endcase
    @(posedge clk);
  endtask

  task automatic rel();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wr_q.size() + re_q.size() + dn_q.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if ((wr_q.size() + re_q.size() + dn_q.size()) != 0) begin
      flag("drain_timeout");
      wr_q.delete();
      re_q.delete();
      dn_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, "_strobes"}, {28'd0, bus.ram_re, bus.ram_we, bus.done, bus.err}, 32'd0);
    chk({tag, "_ram_addr"}, bus.ram_addr, 32'h0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata, 32'h0);
  endtask

  initial begin
    int a0, a1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_mask  = 2'b00;
    bus.req_wdata = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #5;
    chk_idle_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Word store: no read, write at +1, done at +2.
    issue(32'h100, 2'b10, 32'hDEADBEEF, 32'h0, -1, 0, 32'h100, 32'hDEADBEEF, a0);
    rel(); drain();
    // Byte lane 3.
    issue(32'h203, 2'b00, 32'h000000AB, 32'h11223344, 1, 0, 32'h200, 32'hAB223344, a0);
    rel(); drain();
    // Half upper / lower.
    issue(32'h102, 2'b01, 32'h0000CAFE, 32'h11223344, 1, 0, 32'h100, 32'hCAFE3344, a0);
    rel(); drain();
    issue(32'h100, 2'b01, 32'h0000CAFE, 32'h11223344, 1, 0, 32'h100, 32'h1122CAFE, a0);
    rel(); drain();
    // Remaining byte lanes, one with a slower RAM response.
    issue(32'h200, 2'b00, 32'hFFFFFF55, 32'h11223344, 1, 0, 32'h200, 32'h11223355, a0);
    rel(); drain();
    issue(32'h201, 2'b00, 32'h00000066, 32'h11223344, 3, 0, 32'h200, 32'h11226644, a0);
    rel(); drain();
    issue(32'h202, 2'b00, 32'h00000077, 32'h11223344, 1, 0, 32'h200, 32'h11773344, a0);
    rel(); drain();
    // Read timeout: no ram_rvalid at all.
    issue(32'h300, 2'b00, 32'h00000012, 32'h0, -1, 1, 32'h300, 32'h0, a0);
    rel(); drain();
    // ram_rvalid during READ must be ignored, leading to timeout.
    issue(32'h304, 2'b00, 32'h00000034, 32'h99999999, 0, 1, 32'h304, 32'h0, a0);
    rel(); drain();
    // req_valid held through DONE: next accept only in the following IDLE.
    issue(32'h400, 2'b10, 32'h12345678, 32'h0, -1, 0, 32'h400, 32'h12345678, a0);
    issue(32'h404, 2'b10, 32'hA5A5A5A5, 32'h0, -1, 0, 32'h404, 32'hA5A5A5A5, a1);
    chk("b2b_accept_cycle", 32'(a1), 32'(a0 + 3));
    rel(); drain();
    // Reset during WAIT abandons the store.
    issue(32'h500, 2'b00, 32'h00000042, 32'h0, -1, 3, 32'h500, 32'h0, a0);
    rel();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    chk("abandon_queue_empty", 32'(dn_q.size() + wr_q.size() + re_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(32'h504, 2'b00, 32'h00000099, 32'hAABBCCDD, 1, 0, 32'h504, 32'hAABBCC99, a0);
    rel(); drain();
    // Misaligned half and word stores.
`ifdef STORE_MISALIGN_CHECK_EN
    issue(32'h101, 2'b01, 32'h0000BEEF, 32'h11223344, 1, 2, 32'h0, 32'h0, a0);
    rel(); drain();
    issue(32'h102, 2'b11, 32'h01020304, 32'h0, -1, 2, 32'h0, 32'h0, a0);
    rel(); drain();
`else
    issue(32'h101, 2'b01, 32'h0000BEEF, 32'h11223344, 1, 0, 32'h100, 32'h1122BEEF, a0);
    rel(); drain();
    issue(32'h102, 2'b11, 32'h01020304, 32'h0, -1, 0, 32'h100, 32'h01020304, a0);
    rel(); drain();
`endif
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
